// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
//  Module   : serial_sub
//  Purpose  : Bit-serial two's-complement subtractor. Computes
//             diff = a - b - borrow_in one bit per clock (LSB first) through a
//             single full-subtractor cell and a borrow flip-flop, and reports
//             Y86-style flags (zf/sf/of) plus the unsigned borrow-out.
//             Driven by a start/busy/done handshake.
//  Ports    : clk, rst            clock / synchronous active-high reset
//             start               request, honoured only in IDLE or DONE
//             a, b, borrow_in     operands, captured on the accepting edge
//             busy                high while bits are being processed
//             done                one-cycle pulse, result and flags valid
//             diff, borrow_out    result and final borrow
//             zf, sf, of          zero / sign / signed-overflow flags
//  Revision : 1.0  initial release
// ============================================================================
module serial_sub #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  localparam int                 C_IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [C_IDX_W-1:0] C_LAST  = C_IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Operands are held in right-shifting registers so the active bit is
  // always at position 0; the MSBs are kept separately for the overflow flag.
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_diff_sh;
  logic               r_a_msb;
  logic               r_b_msb;
  logic               r_br;
  logic [C_IDX_W-1:0] r_idx;

  logic             w_accept;
  logic             w_last;
  logic             w_a_i;
  logic             w_b_i;
  logic             w_d_i;
  logic             w_br_nxt;
  logic [WIDTH-1:0] w_final;

  // --------------------------------------------------------------------------
  // Full-subtractor cell
  // --------------------------------------------------------------------------
  assign w_a_i    = r_a_sh[0];
  assign w_b_i    = r_b_sh[0];
  assign w_d_i    = w_a_i ^ w_b_i ^ r_br;
  assign w_br_nxt = (~w_a_i & w_b_i) | (~(w_a_i ^ w_b_i) & r_br);

  // Result bits enter at the MSB and walk down; after WIDTH shifts bit 0
  // holds the first computed bit.
  assign w_final  = {w_d_i, r_diff_sh[WIDTH-1:1]};

  assign w_accept = start & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_last   = (r_idx == C_LAST);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_diff_sh  <= '0;
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
      r_br       <= 1'b0;
      r_idx      <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zf         <= 1'b0;
      sf         <= 1'b0;
      of         <= 1'b0;
    end else if (w_accept) begin
      // Published result registers are left untouched here so the previous
      // answer stays visible until the new one completes.
      r_a_sh    <= a;
      r_b_sh    <= b;
      r_a_msb   <= a[WIDTH-1];
      r_b_msb   <= b[WIDTH-1];
      r_br      <= borrow_in;
      r_diff_sh <= '0;
      r_idx     <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sh    <= r_a_sh >> 1;
      r_b_sh    <= r_b_sh >> 1;
      r_br      <= w_br_nxt;
      r_diff_sh <= w_final;
      r_idx     <= r_idx + 1'b1;
      if (w_last) begin
        diff       <= w_final;
        borrow_out <= w_br_nxt;
        zf         <= (w_final == '0);
        sf         <= w_final[WIDTH-1];
        of         <= (r_a_msb ^ r_b_msb) & (w_final[WIDTH-1] ^ r_a_msb);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_sub
//  Purpose  : Directed, self-checking bench for serial_sub at WIDTH=8.
//             Each scenario task drives its stimulus and compares the DUT
//             outputs against hand-computed values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_sub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         borrow_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         zf;
  logic         sf;
  logic         of;

  int vectors     = 0;
  int miscompares = 0;

  // {diff, borrow_out, zf, sf, of}
  logic [W+3:0] res;
  assign res = {diff, borrow_out, zf, sf, of};

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .zf         (zf),
    .sf         (sf),
    .of         (of)
  );

  // Present operands, let the next edge accept them, then scramble the
  // inputs so any re-sampling would corrupt the result. Returns in cycle 1.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bin);
    start     = 1'b1;
    a         = av;
    b         = bv;
    borrow_in = bin;
    @(posedge clk);
    #1;
    start     = 1'b0;
    a         = 8'hC3;
    b         = 8'h3C;
    borrow_in = ~bin;
  endtask

  // Advance cycle by cycle until done is seen (bounded); cyc is the cycle
  // number after the accept edge at which done was observed.
  task automatic wait_done(input int from, output int cyc);
    cyc = from;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy/done got %b required 00", {busy, done});
    end
    vectors++;
    if (res !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_result: {diff,bo,zf,sf,of} got %h required 000", res);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    int lat;
    launch(8'h05, 8'h03, 1'b0);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_busy: got %b required 1", busy);
    end
    wait_done(1, lat);
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d required 9", lat);
    end
    vectors++;
    if (res !== {8'h02, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL basic_result: got %h required %h", res, {8'h02, 4'b0000});
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({done, busy, res} !== {2'b00, 8'h02, 4'b0000}) begin
      miscompares++;
      $display("FAIL basic_pulse_hold: {done,busy,res} got %h required %h",
               {done, busy, res}, {2'b00, 8'h02, 4'b0000});
    end
  endtask

  task automatic test_negative;
    int lat;
    launch(8'h03, 8'h05, 1'b0);
    wait_done(1, lat);
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("FAIL neg_latency: got %0d required 9", lat);
    end
    vectors++;
    if (res !== {8'hFE, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL neg_result: got %h required %h", res, {8'hFE, 4'b1010});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_overflow;
    int lat;
    launch(8'h80, 8'h01, 1'b0);
    wait_done(1, lat);
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("FAIL ovf1_latency: got %0d required 9", lat);
    end
    vectors++;
    if (res !== {8'h7F, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL ovf1_result: got %h required %h", res, {8'h7F, 4'b0001});
    end
    @(posedge clk);
    #1;
    launch(8'h7F, 8'hFF, 1'b0);
    wait_done(1, lat);
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("FAIL ovf2_latency: got %0d required 9", lat);
    end
    vectors++;
    if (res !== {8'h80, 1'b1, 1'b0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL ovf2_result: got %h required %h", res, {8'h80, 4'b1011});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_equal;
    int lat;
    launch(8'h5A, 8'h5A, 1'b0);
    wait_done(1, lat);
    vectors++;
    if (res !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL eq_zero_result: got %h required %h", res, {8'h00, 4'b0100});
    end
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("FAIL eq_zero_latency: got %0d required 9", lat);
    end
    @(posedge clk);
    #1;
    launch(8'h5A, 8'h5A, 1'b1);
    wait_done(1, lat);
    vectors++;
    if (res !== {8'hFF, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL eq_bin_result: got %h required %h", res, {8'hFF, 4'b1010});
    end
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("FAIL eq_bin_latency: got %0d required 9", lat);
    end
    @(posedge clk);
    #1;
  endtask

  // Ends in the DONE cycle so the back-to-back test can start immediately.
  task automatic test_ignore_start;
    int lat;
    launch(8'h11, 8'h22, 1'b0);
    vectors++;
    if (res !== {8'hFF, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL ign_hold_prev: got %h required %h", res, {8'hFF, 4'b1010});
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    start     = 1'b1;
    a         = 8'h40;
    b         = 8'h01;
    borrow_in = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(4, lat);
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("FAIL ign_latency: got %0d required 9", lat);
    end
    vectors++;
    if (res !== {8'hEF, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL ign_result: got %h required %h", res, {8'hEF, 4'b1010});
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_in_done: done got %b required 1", done);
    end
    launch(8'h64, 8'h0A, 1'b1);
    vectors++;
    if ({busy, done} !== 2'b10) begin
      miscompares++;
      $display("FAIL b2b_accept: busy/done got %b required 10", {busy, done});
    end
    wait_done(1, lat);
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("FAIL b2b_latency: got %0d required 9", lat);
    end
    vectors++;
    if (res !== {8'h59, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_result: got %h required %h", res, {8'h59, 4'b0000});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    int   lat;
    logic seen;
    launch(8'hAA, 8'h55, 1'b0);
    // cycle 1 holds bit 0; four more edges reach bit 4
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL rstmid_ctrl: busy/done got %b required 00", {busy, done});
    end
    vectors++;
    if (res !== 12'h000) begin
      miscompares++;
      $display("FAIL rstmid_result: got %h required 000", res);
    end
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_quiet: activity after reset got %b required 0", seen);
    end
    launch(8'h0F, 8'hF0, 1'b0);
    wait_done(1, lat);
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("FAIL rstmid_fresh_latency: got %0d required 9", lat);
    end
    vectors++;
    if (res !== {8'h1F, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL rstmid_fresh_result: got %h required %h", res, {8'h1F, 4'b1000});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    borrow_in = 1'b0;
    test_reset();
    test_basic();
    test_negative();
    test_overflow();
    test_equal();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
